// File: rtl/game_sequencer_if.sv
// Signal bundle between the whack-a-mole top level and the round/lives sequencer.
interface game_sequencer_if;
  logic       start;
  logic       hit;
  logic       miss;
  logic       mole_req;
  logic       mole_active;
  logic       game_end;
  logic [2:0] state;
  logic [7:0] round;
  logic [2:0] lives_left;

  modport master (
    output start, hit, miss,
    input  mole_req, mole_active, game_end,
    input  state, round, lives_left
  );

  modport slave (
    input  start, hit, miss,
    output mole_req, mole_active, game_end,
    output state, round, lives_left
  );
endinterface

// File: rtl/game_sequencer.sv
// Whack-a-mole round/lives sequencer: countdown, mole windows, hits, lives, game over.
// Define SEQ_SPEEDUP_EN to shrink the mole window on every hit.
module game_sequencer #(
  parameter int TICK_DIV        = 1000,
  parameter int COUNTDOWN_TICKS = 3,
  parameter int INIT_WINDOW     = 8,
  parameter int MIN_WINDOW      = 2,
  parameter int WINDOW_STEP     = 1,
  parameter int ROUNDS          = 16,
  parameter int LIVES           = 3
) (
  input  logic             clk,
  input  logic             rst,
  game_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    SPAWN     = 3'd2,
    ACTIVE    = 3'd3,
    OVER      = 3'd4
  } state_e;

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PS_MAX   = PW'(TICK_DIV - 1);
  localparam logic [7:0]    CD_INIT  = 8'(COUNTDOWN_TICKS);
  localparam logic [7:0]    WIN_INIT = 8'(INIT_WINDOW);
  localparam logic [7:0]    RND_MAX  = 8'(ROUNDS);
  localparam logic [2:0]    LV_INIT  = 3'(LIVES);
`ifdef SEQ_SPEEDUP_EN
  localparam logic [7:0]    WIN_MIN  = 8'(MIN_WINDOW);
  localparam logic [7:0]    WIN_STEP = 8'(WINDOW_STEP);
`endif

  state_e        state_q, state_d;
  logic          start_q;
  logic [PW-1:0] ps_q, ps_d;
  logic [7:0]    cd_q, cd_d;
  logic [7:0]    win_cnt_q, win_cnt_d;
  logic [7:0]    window_q, window_d;
  logic [7:0]    round_q, round_d;
  logic [2:0]    lives_q, lives_d;
  logic          tick;
  logic          start_rise;
  logic          timeout;

  assign tick       = (ps_q == PS_MAX);
  assign start_rise = bus.start & ~start_q;
  assign timeout    = tick && (win_cnt_q == 8'd1);

  always_comb begin
    state_d   = state_q;
    ps_d      = tick ? '0 : ps_q + PW'(1);
    cd_d      = cd_q;
    win_cnt_d = win_cnt_q;
    window_d  = window_q;
    round_d   = round_q;
    lives_d   = lives_q;
    unique case (state_q)
      IDLE, OVER: begin
        ps_d = '0;
        if (start_rise) begin
          state_d  = COUNTDOWN;
          cd_d     = CD_INIT;
          round_d  = '0;
          lives_d  = LV_INIT;
          window_d = WIN_INIT;
        end
      end
      COUNTDOWN: begin
        if (tick) begin
          cd_d = cd_q - 8'd1;
          if (cd_q == 8'd1) state_d = SPAWN;
        end
      end
      SPAWN: begin
        ps_d      = '0;
        win_cnt_d = window_q;
        state_d   = ACTIVE;
      end
      ACTIVE: begin
        if (tick) win_cnt_d = win_cnt_q - 8'd1;
        // hit beats timeout beats miss; a miss coinciding with timeout costs one life
        if (bus.hit) begin
          round_d = round_q + 8'd1;
          state_d = (round_q + 8'd1 == RND_MAX) ? OVER : SPAWN;
`ifdef SEQ_SPEEDUP_EN
          window_d = (window_q <= WIN_MIN + WIN_STEP) ? WIN_MIN
                                                      : window_q - WIN_STEP;
`endif
        end else if (timeout) begin
          lives_d = lives_q - 3'd1;
          state_d = (lives_q == 3'd1) ? OVER : SPAWN;
        end else if (bus.miss) begin
          lives_d = lives_q - 3'd1;
          if (lives_q == 3'd1) state_d = OVER;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      ps_q      <= '0;
      cd_q      <= '0;
      win_cnt_q <= '0;
      window_q  <= WIN_INIT;
      round_q   <= '0;
      lives_q   <= LV_INIT;
    end else begin
      state_q   <= state_d;
      start_q   <= bus.start;
      ps_q      <= ps_d;
      cd_q      <= cd_d;
      win_cnt_q <= win_cnt_d;
      window_q  <= window_d;
      round_q   <= round_d;
      lives_q   <= lives_d;
    end
  end

  assign bus.mole_req    = (state_q == SPAWN);
  assign bus.mole_active = (state_q == ACTIVE);
  assign bus.game_end    = (state_q == OVER);
  assign bus.state       = state_q;
  assign bus.round       = round_q;
  assign bus.lives_left  = lives_q;

endmodule
